rv32_amo_seq: RTL and testbench
===============================

Name: rv32_amo_seq

Overview:
Multi-cycle sequencer that executes RV32A instructions (LR.W, SC.W, AMO*.W) for the single-cycle rv32 core. It runs each access as a read-modify-write over a ready/ack memory handshake and stalls the core until the access completes. It also owns the LR/SC reservation register. It sits between the core's decode/writeback and the data-memory port mux.

Parameters:
TIMEOUT, 16, cycles allowed per memory phase before abort; 0 disables the timeout.

Ports:
clk  in  1  clock
clrn  in  1  asynchronous active-low reset
amo_req  in  1  core is presenting an A-extension instruction; held stable until amo_done
amo_op  in  5  funct5 (inst[31:27])
amo_addr  in  32  rs1 value (effective address)
amo_wdata  in  32  rs2 value
amo_busy  out  1  stall the core (pc hold, no regfile write)
amo_done  out  1  one-cycle pulse; core writes amo_rdata to rd and advances pc
amo_rdata  out  32  result for rd
amo_err  out  1  valid with amo_done: misaligned or timeout; core suppresses rd write
snoop_we  in  1  core plain store in progress (any write byte enable)
snoop_addr  in  32  address of that store
resv_clr  in  1  trap/context switch; clears reservation
mem_addr  out  32  word address, bits [1:0]=00
mem_wdata  out  32  store data
mem_we  out  4  byte write enables (1111 or 0000)
mem_rd  out  1  read request
mem_rdata  in  32  read data, valid in the ack cycle
mem_ack  in  1  completes the current request (same-cycle ack allowed)

Behaviour:
- Reset (async, clrn=0): state IDLE; all outputs 0; reservation invalid; timeout counter 0. Reset mid-operation abandons the access, with no done pulse.
- Decided fact: reset clrn, asynchronous, active-low; clock clk.
- amo_busy = amo_req & ~amo_done (combinational), so the core stalls in the request cycle.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - amo_req with amo_addr[1:0]!=0 -> DONE, err=1.
  - LR / AMO* -> RD.
  - SC -> WR when the reservation is valid and resv_addr==amo_addr[31:2]; otherwise -> DONE with rdata=1. The reservation is cleared on leaving IDLE for any SC.
- RD: mem_rd=1, mem_addr={amo_addr[31:2],2'b00}, held until mem_ack.
  - On ack, old value is latched into rdata.
  - LR: set reservation (valid=1, addr=amo_addr[31:2]) -> DONE.
  - AMO*: -> WR.
- WR: mem_we=1111, held until mem_ack.
  - mem_wdata = amo_wdata for SC/SWAP; otherwise f(old, amo_wdata).
  - f covers ADD, XOR, AND, OR, MIN/MAX (signed), MINU/MAXU (unsigned), 32-bit wrap-around.
  - On ack -> DONE. SC sets rdata=0.
- DONE: amo_done=1 for exactly one cycle -> IDLE. Outputs mem_rd/mem_we are 0.
- Latency with same-cycle ack:
  - AMO: 4 cycles (IDLE, RD, WR, DONE).
  - LR: 3 cycles.
  - Successful SC: 3 cycles.
  - Failed or misaligned: 2 cycles.
- Timeout: counter is cleared on entry to RD/WR and increments each cycle without ack. When it reaches TIMEOUT, mem_rd/mem_we are dropped -> DONE with err=1, rdata=0, reservation cleared. Ack in the TIMEOUT-th cycle counts as success.
- Reservation clear sources: resv_clr, snoop_we with snoop_addr[31:2]==resv_addr, any SC, timeout. A clear and a set in the same cycle resolve to clear.
- Unknown funct5: treated as misaligned (err=1, no memory access).
- Back-to-back: a new amo_req in the cycle after DONE is accepted normally.

Decomposition:
- Package rv32_amo_pkg: funct5 constants (LR 00010, SC 00011, SWAP 00001, ADD 00000, XOR 00100, AND 01100, OR 01000, MIN 10000, MAX 10100, MINU 11000, MAXU 11100) and the state enum.
- Sub-module rv32_amo_alu: combinational f(op, old, src) -> new.

Test Plan:
- AMOADD at 0x100, mem=0x7FFFFFFF, rs2=1, ack immediate -> WR data 0x80000000; rd=0x7FFFFFFF; done 3 cycles after accept; busy high 3 cycles.
- AMOMIN vs AMOMINU with old=0xFFFFFFFF, rs2=0x00000001 -> writes 0xFFFFFFFF and 0x00000001 respectively.
- LR 0x200 then SC 0x200 (data 0xA5A5A5A5) -> SC writes, rd=0. A second SC without an LR -> no mem_we, rd=1.
- LR 0x200, then snoop_we to 0x202, then SC 0x200 -> SC fails, rd=1, no memory write.
- amo_addr=0x103 -> done after 1 cycle, err=1, mem_rd and mem_we never asserted.
- TIMEOUT=4, mem_ack stuck 0 during RD -> mem_rd high 4 cycles, then done with err=1. Assert clrn mid-RD on a rerun -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/rv32_amo_pkg.sv
// Shared definitions for the RV32A sequencer: funct5 encodings, FSM states and an op-decode helper.
package rv32_amo_pkg;

  localparam logic [4:0] AmoAdd  = 5'b00000;
  localparam logic [4:0] AmoSwap = 5'b00001;
  localparam logic [4:0] AmoLr   = 5'b00010;
  localparam logic [4:0] AmoSc   = 5'b00011;
  localparam logic [4:0] AmoXor  = 5'b00100;
  localparam logic [4:0] AmoOr   = 5'b01000;
  localparam logic [4:0] AmoAnd  = 5'b01100;
  localparam logic [4:0] AmoMin  = 5'b10000;
  localparam logic [4:0] AmoMax  = 5'b10100;
  localparam logic [4:0] AmoMinu = 5'b11000;
  localparam logic [4:0] AmoMaxu = 5'b11100;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} amo_state_e;

  function automatic logic op_known(input logic [4:0] op);
    case (op)
      AmoAdd, AmoSwap, AmoLr, AmoSc, AmoXor, AmoOr, AmoAnd,
      AmoMin, AmoMax, AmoMinu, AmoMaxu: op_known = 1'b1;
      default:                          op_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_amo_alu.sv
// Combinational AMO combine function: new memory word from the old word and rs2.
module rv32_amo_alu
  import rv32_amo_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [31:0] i_old,
  input  logic [31:0] i_src,
  output logic [31:0] o_new
);

  logic w_slt;
  logic w_ult;

  assign w_slt = $signed(i_old) < $signed(i_src);
  assign w_ult = i_old < i_src;

  // SWAP and SC store rs2 unchanged, which is also the default.
  always_comb begin
    o_new = i_src;
    case (i_op)
      AmoAdd:  o_new = i_old + i_src;
      AmoXor:  o_new = i_old ^ i_src;
      AmoAnd:  o_new = i_old & i_src;
      AmoOr:   o_new = i_old | i_src;
      AmoMin:  o_new = w_slt ? i_old : i_src;
      AmoMax:  o_new = w_slt ? i_src : i_old;
      AmoMinu: o_new = w_ult ? i_old : i_src;
      AmoMaxu: o_new = w_ult ? i_src : i_old;
      default: o_new = i_src;
    endcase
  end

endmodule

// File: rtl/rv32_amo_seq.sv
// RV32A sequencer: runs LR/SC/AMO as read-modify-write over a ready/ack memory port,
// stalls the core meanwhile and owns the LR/SC reservation.
module rv32_amo_seq
  import rv32_amo_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_amo_req,
  input  logic [4:0]  i_amo_op,
  input  logic [31:0] i_amo_addr,
  input  logic [31:0] i_amo_wdata,
  output logic        o_amo_busy,
  output logic        o_amo_done,
  output logic [31:0] o_amo_rdata,
  output logic        o_amo_err,
  input  logic        i_snoop_we,
  input  logic [31:0] i_snoop_addr,
  input  logic        i_resv_clr,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_we,
  output logic        o_mem_rd,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  amo_state_e  r_state, w_state_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic        r_err, w_err_d;
  logic [31:0] r_cnt, w_cnt_d;
  logic        r_resv_valid;
  logic [29:0] r_resv_addr;

  logic        w_resv_set;
  logic        w_resv_kill;
  logic        w_resv_hit;
  logic        w_snoop_hit;
  logic        w_tmo;
  logic        w_done;
  logic [31:0] w_word;
  logic [31:0] w_alu_new;
  logic        w_unused_snoop;

  assign w_done         = (r_state == StDone);
  assign w_word         = {i_amo_addr[31:2], 2'b00};
  assign w_resv_hit     = r_resv_valid && (r_resv_addr == i_amo_addr[31:2]);
  assign w_snoop_hit    = i_snoop_we && (i_snoop_addr[31:2] == r_resv_addr);
  // The TIMEOUT-th waiting cycle is the last one in which an ack still counts.
  assign w_tmo          = (TIMEOUT != 0) && (r_cnt == TIMEOUT - 1);
  assign w_unused_snoop = ^i_snoop_addr[1:0];

  assign o_amo_done  = w_done;
  assign o_amo_busy  = i_amo_req & ~w_done;
  assign o_amo_rdata = r_rdata;
  assign o_amo_err   = w_done & r_err;

  rv32_amo_alu u_alu (
    .i_op  (i_amo_op),
    .i_old (r_rdata),
    .i_src (i_amo_wdata),
    .o_new (w_alu_new)
  );

  always_comb begin
    w_state_d   = r_state;
    w_rdata_d   = r_rdata;
    w_err_d     = r_err;
    w_cnt_d     = r_cnt;
    w_resv_set  = 1'b0;
    w_resv_kill = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_we    = 4'b0000;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    case (r_state)
      StIdle: begin
        if (i_amo_req) begin
          w_cnt_d   = 32'h0;
          w_err_d   = 1'b0;
          w_rdata_d = 32'h0;
          if ((i_amo_addr[1:0] != 2'b00) || !op_known(i_amo_op)) begin
            w_err_d   = 1'b1;
            w_state_d = StDone;
          end else if (i_amo_op == AmoSc) begin
            w_resv_kill = 1'b1;
            if (w_resv_hit) begin
              w_state_d = StWr;
            end else begin
              w_rdata_d = 32'h1;
              w_state_d = StDone;
            end
          end else begin
            w_state_d = StRd;
          end
        end
      end
      StRd: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = w_word;
        if (i_mem_ack) begin
          w_rdata_d = i_mem_rdata;
          w_cnt_d   = 32'h0;
          if (i_amo_op == AmoLr) begin
            w_resv_set = 1'b1;
            w_state_d  = StDone;
          end else begin
            w_state_d = StWr;
          end
        end else if (w_tmo) begin
          w_err_d     = 1'b1;
          w_rdata_d   = 32'h0;
          w_resv_kill = 1'b1;
          w_state_d   = StDone;
        end else begin
          w_cnt_d = r_cnt + 32'h1;
        end
      end
      StWr: begin
        o_mem_we    = 4'b1111;
        o_mem_addr  = w_word;
        o_mem_wdata = w_alu_new;
        if (i_mem_ack) begin
          if (i_amo_op == AmoSc) w_rdata_d = 32'h0;
          w_state_d = StDone;
        end else if (w_tmo) begin
          w_err_d     = 1'b1;
          w_rdata_d   = 32'h0;
          w_resv_kill = 1'b1;
          w_state_d   = StDone;
        end else begin
          w_cnt_d = r_cnt + 32'h1;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= StIdle;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_cnt   <= 32'h0;
    end else begin
      r_state <= w_state_d;
      r_rdata <= w_rdata_d;
      r_err   <= w_err_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Any clear source beats a simultaneous LR set.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_resv_valid <= 1'b0;
      r_resv_addr  <= 30'h0;
    end else if (w_resv_kill || i_resv_clr || w_snoop_hit) begin
      r_resv_valid <= 1'b0;
    end else if (w_resv_set) begin
      r_resv_valid <= 1'b1;
      r_resv_addr  <= i_amo_addr[31:2];
    end
  end

endmodule

// File: tb/tb_rv32_amo_seq.sv
// Scoreboard bench for rv32_amo_seq: directed ops, a word-array memory model and a negedge monitor.
module tb_rv32_amo_seq;
  import rv32_amo_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic        amo_req;
  logic [4:0]  amo_op;
  logic [31:0] amo_addr, amo_wdata;
  logic        amo_busy, amo_done, amo_err;
  logic [31:0] amo_rdata;
  logic        snoop_we, resv_clr;
  logic [31:0] snoop_addr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic        mem_rd, mem_ack;

  always #5 clk = ~clk;

  rv32_amo_seq #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .i_amo_req    (amo_req),
    .i_amo_op     (amo_op),
    .i_amo_addr   (amo_addr),
    .i_amo_wdata  (amo_wdata),
    .o_amo_busy   (amo_busy),
    .o_amo_done   (amo_done),
    .o_amo_rdata  (amo_rdata),
    .o_amo_err    (amo_err),
    .i_snoop_we   (snoop_we),
    .i_snoop_addr (snoop_addr),
    .i_resv_clr   (resv_clr),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_we     (mem_we),
    .o_mem_rd     (mem_rd),
    .i_mem_rdata  (mem_rdata),
    .i_mem_ack    (mem_ack)
  );

  // Memory model: 256 words, combinational ack when enabled.
  logic [31:0] mem [0:255];
  logic        ack_en;
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  assign mem_ack   = ack_en & (mem_rd | (|mem_we));
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_ack && (mem_we == 4'b1111)) mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct {logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int total = 0;
  int bad = 0;
  int rd_cyc = 0;
  int we_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares every done pulse and every acked write against the queues.
  rsp_t m_rsp;
  wr_t  m_wr;
  always @(negedge clk) begin
    if (clrn) begin
      if (mem_rd) rd_cyc++;
      if (mem_we != 4'b0000) we_cyc++;
      if (amo_done) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          m_rsp = rsp_q.pop_front();
          chk("rd_value", amo_rdata, m_rsp.rdata);
          chk("err_flag", {31'b0, amo_err}, {31'b0, m_rsp.err});
        end
      end
      if ((mem_we != 4'b0000) && mem_ack) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
        end else begin
          m_wr = wr_q.pop_front();
          chk("wr_addr", mem_addr, m_wr.addr);
          chk("wr_data", mem_wdata, m_wr.data);
          chk("wr_be", {28'b0, mem_we}, 32'hF);
        end
      end
    end
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clk);
    #1;
    pl_en  = 1'b1;
    pl_idx = addr[9:2];
    pl_val = val;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic run(input string nm, input logic [4:0] op, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                     input logic do_wr, input logic [31:0] exp_wd, input int exp_lat);
    int  lat;
    int  busy;
    bit  seen;
    rsp_q.push_back('{exp_rd, exp_err});
    if (do_wr) wr_q.push_back('{{addr[31:2], 2'b00}, exp_wd});
    @(negedge clk);
    #1;
    amo_req   = 1'b1;
    amo_op    = op;
    amo_addr  = addr;
    amo_wdata = wd;
    lat  = 0;
    busy = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (amo_busy) busy++;
      if (amo_done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      #1;
      lat++;
    end
    if (!seen) chk({nm, "_no_done"}, 32'h0, 32'h1);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_busy_cycles"}, busy, exp_lat);
    amo_req = 1'b0;
  endtask

  int rd0, we0;

  initial begin
    clrn = 1'b0; amo_req = 1'b0; amo_op = 5'b0; amo_addr = 32'h0; amo_wdata = 32'h0;
    snoop_we = 1'b0; snoop_addr = 32'h0; resv_clr = 1'b0;
    ack_en = 1'b1; pl_en = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;

    preload(32'h100, 32'h7FFF_FFFF);
    preload(32'h104, 32'hFFFF_FFFF);
    preload(32'h108, 32'h8000_0000);
    preload(32'h10C, 32'hF0F0_F0F0);
    preload(32'h110, 32'h1234_5678);
    preload(32'h200, 32'h1111_1111);
    #1;
    chk("rst_done", {31'b0, amo_done}, 32'h0);
    chk("rst_busy", {31'b0, amo_busy}, 32'h0);
    chk("rst_err", {31'b0, amo_err}, 32'h0);
    chk("rst_rdata", amo_rdata, 32'h0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
    chk("rst_mem_we", {28'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    clrn = 1'b1;

    run("amoadd",  AmoAdd,  32'h100, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 32'h8000_0000, 3);
    run("amomin",  AmoMin,  32'h104, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, 3);
    run("amominu", AmoMinu, 32'h104, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1, 32'h0000_0001, 3);
    run("amomax",  AmoMax,  32'h108, 32'h0000_0005, 32'h8000_0000, 0, 1, 32'h0000_0005, 3);
    run("amomaxu", AmoMaxu, 32'h108, 32'h8000_0000, 32'h0000_0005, 0, 1, 32'h8000_0000, 3);
    run("amoxor",  AmoXor,  32'h10C, 32'hFF00_FF00, 32'hF0F0_F0F0, 0, 1, 32'h0FF0_0FF0, 3);
    run("amoand",  AmoAnd,  32'h10C, 32'h0000_FFFF, 32'h0FF0_0FF0, 0, 1, 32'h0000_0FF0, 3);
    run("amoor",   AmoOr,   32'h10C, 32'hF000_0000, 32'h0000_0FF0, 0, 1, 32'hF000_0FF0, 3);
    run("amoswap", AmoSwap, 32'h110, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 32'hDEAD_BEEF, 3);

    run("lr",       AmoLr, 32'h200, 32'h0,          32'h1111_1111, 0, 0, 32'h0,          2);
    run("sc_ok",    AmoSc, 32'h200, 32'hA5A5_A5A5, 32'h0,         0, 1, 32'hA5A5_A5A5, 2);
    we0 = we_cyc;
    run("sc_again", AmoSc, 32'h200, 32'h0000_0001, 32'h1,         0, 0, 32'h0,          1);
    chk("sc_again_no_we", we_cyc - we0, 0);

    run("lr2", AmoLr, 32'h200, 32'h0, 32'hA5A5_A5A5, 0, 0, 32'h0, 2);
    @(negedge clk);
    #1;
    snoop_we   = 1'b1;
    snoop_addr = 32'h202;
    @(negedge clk);
    #1;
    snoop_we = 1'b0;
    we0 = we_cyc;
    run("sc_snooped", AmoSc, 32'h200, 32'h0000_0077, 32'h1, 0, 0, 32'h0, 1);
    chk("sc_snooped_no_we", we_cyc - we0, 0);

    rd0 = rd_cyc;
    we0 = we_cyc;
    run("misaligned", AmoAdd, 32'h103, 32'h1, 32'h0, 1, 0, 32'h0, 1);
    run("bad_funct5", 5'b00101, 32'h100, 32'h1, 32'h0, 1, 0, 32'h0, 1);
    chk("err_no_rd", rd_cyc - rd0, 0);
    chk("err_no_we", we_cyc - we0, 0);

    ack_en = 1'b0;
    rd0 = rd_cyc;
    run("timeout", AmoAdd, 32'h100, 32'h1, 32'h0, 1, 0, 32'h0, 5);
    chk("timeout_rd_cycles", rd_cyc - rd0, 4);
    ack_en = 1'b1;

    run("swap_after_tmo", AmoSwap, 32'h110, 32'h0102_0304, 32'hDEAD_BEEF, 0, 1, 32'h0102_0304, 3);

    // Reset in the middle of a stalled read must abandon the access silently.
    ack_en = 1'b0;
    @(negedge clk);
    #1;
    amo_req  = 1'b1;
    amo_op   = AmoLr;
    amo_addr = 32'h200;
    @(negedge clk);
    #1;
    chk("pre_rst_mem_rd", {31'b0, mem_rd}, 32'h1);
    @(negedge clk);
    #1;
    clrn    = 1'b0;
    amo_req = 1'b0;
    #1;
    chk("midrst_mem_rd", {31'b0, mem_rd}, 32'h0);
    chk("midrst_mem_we", {28'b0, mem_we}, 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_done", {31'b0, amo_done}, 32'h0);
    chk("midrst_rdata", amo_rdata, 32'h0);
    chk("midrst_busy", {31'b0, amo_busy}, 32'h0);
    repeat (2) @(negedge clk);
    clrn   = 1'b1;
    ack_en = 1'b1;
    repeat (4) @(negedge clk);
    #1;

    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
